alu_operand_stage: RTL

ID/EX pipeline stage that sits directly upstream of the 32-bit ALU and drives its ALUOperation, A and B inputs from registers.
- Captures decoded operands and selects the immediate for B.
- Forwards in-flight results at capture time from two sources: the ALU output fed back, and the MEM/WB write-back.
- Detects load-use hazards, inserting exactly one bubble and stalling decode.
- Supports flush for branch redirect.

---
 rtl/alu_pkg.sv | 15 +
 rtl/operand_fwd_mux.sv | 32 +++
 rtl/alu_operand_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and default datapath widths,
// used by the ALU, its control decoder and the operand stage.
package alu_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_REG_AW = 5;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_NOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
endpackage

// File: rtl/operand_fwd_mux.sv
// Three-way priority operand select: EX result, then MEM/WB write data,
// then register-file data. Register 0 is never forwarded.
module operand_fwd_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fwd_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_fwd_en && (ex_rd != '0) && (ex_rd == addr);
  assign mem_hit = mem_fwd_en && (mem_rd != '0) && (mem_rd == addr);

  always_comb begin
    data = rf_data;
    if (ex_hit)       data = ex_data;
    else if (mem_hit) data = mem_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU, with operand forwarding and load-use stall.
// Optional bubble counter enabled by defining ALU_STAGE_BUBBLE_CNT_EN.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_AW = ALU_REG_AW
`ifdef ALU_STAGE_BUBBLE_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [3:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              id_stall,
  output logic [3:0]        ALUOperation,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rt_data
`ifdef ALU_STAGE_BUBBLE_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt
`endif
);

  logic              vld_p1;
  logic              rw_p1;
  logic              mr_p1;
  logic [3:0]        op_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [DATA_W-1:0] rtd_p1;

  logic              ex_fwd_en;
  logic [DATA_W-1:0] rs_fwd_p0;
  logic [DATA_W-1:0] rt_fwd_p0;
  logic              load_use_p0;
  logic              bubble_p0;

  // Only a non-load EX instruction has its result available on ex_alu_result.
  assign ex_fwd_en = vld_p1 & rw_p1 & ~mr_p1;

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_fwd (
    .addr(id_rs_addr), .rf_data(id_rs_data),
    .ex_fwd_en(ex_fwd_en), .ex_rd(rd_p1), .ex_data(ex_alu_result),
    .mem_fwd_en(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_wdata),
    .data(rs_fwd_p0)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_fwd (
    .addr(id_rt_addr), .rf_data(id_rt_data),
    .ex_fwd_en(ex_fwd_en), .ex_rd(rd_p1), .ex_data(ex_alu_result),
    .mem_fwd_en(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_wdata),
    .data(rt_fwd_p0)
  );

  assign load_use_p0 = id_valid & vld_p1 & mr_p1 & (rd_p1 != '0) &
                       ((rd_p1 == id_rs_addr) | (~id_alusrc & (rd_p1 == id_rt_addr)));
  assign bubble_p0   = flush | load_use_p0 | ~id_valid;
  assign id_stall    = ~reset & ~flush & load_use_p0;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (reset || bubble_p0) begin
      vld_p1 <= 1'b0;
      rw_p1  <= 1'b0;
      mr_p1  <= 1'b0;
      op_p1  <= OP_AND;
      a_p1   <= '0;
      b_p1   <= '0;
      rd_p1  <= '0;
      rtd_p1 <= '0;
    end else begin
      vld_p1 <= 1'b1;
      rw_p1  <= id_reg_write;
      mr_p1  <= id_mem_read;
      op_p1  <= id_aluop;
      a_p1   <= rs_fwd_p0;
      b_p1   <= id_alusrc ? id_imm : rt_fwd_p0;
      rd_p1  <= id_rd_addr;
      rtd_p1 <= rt_fwd_p0;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_reg_write = rw_p1;
  assign ex_mem_read  = mr_p1;
  assign ALUOperation = op_p1;
  assign A            = a_p1;
  assign B            = b_p1;
  assign ex_rd        = rd_p1;
  assign ex_rt_data   = rtd_p1;

`ifdef ALU_STAGE_BUBBLE_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_p1;

  // Idle slots (id_valid=0) are not counted; only hazard and flush bubbles.
  always_ff @(posedge clk) begin
    if (reset)                      cnt_p1 <= '0;
    else if (flush || load_use_p0)  cnt_p1 <= sat_inc(cnt_p1);
  end

  assign bubble_cnt = cnt_p1;
`endif

endmodule
